vram_port_arbiter: RTL

- Owns the single-port synchronous VRAM and shares it between the VGA scanout read requester and the frame-writer write requester.
- Scanout reads always have strict priority. Writes are posted into a small FIFO and drained on any cycle without a read.
- Also sequences a whole-memory fill operation (screen clear) on command, interleaved with scanout reads.

---
 rtl/vram_port_arbiter_if.sv | 44 ++++
 rtl/vram_port_arbiter.sv | 124 ++++++++++++
 2 files changed

// File: rtl/vram_port_arbiter_if.sv
// Port bundle for the VRAM arbiter: scanout reads, posted writes, fill control and the RAM side.
// The master side is everything around the arbiter: both requesters and the RAM itself.
interface vram_port_arbiter_if #(
    parameter int ADDR_W      = 14,
    parameter int DATA_W      = 16,
    parameter int WFIFO_DEPTH = 4
);
    localparam int CNT_W = $clog2(WFIFO_DEPTH) + 1;

    logic              disp_rd_req;
    logic [ADDR_W-1:0] disp_rd_addr;
    logic              disp_rd_valid;
    logic [DATA_W-1:0] disp_rd_data;

    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    logic              fill_start;
    logic [DATA_W-1:0] fill_value;
    logic              fill_busy;
    logic              fill_done;
    logic [CNT_W-1:0]  wfifo_count;

    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    modport master (
        output disp_rd_req, disp_rd_addr, wr_valid, wr_addr, wr_data,
               fill_start, fill_value, ram_rdata,
        input  disp_rd_valid, disp_rd_data, wr_ready, fill_busy, fill_done,
               wfifo_count, ram_addr, ram_we, ram_wdata
    );

    modport slave (
        input  disp_rd_req, disp_rd_addr, wr_valid, wr_addr, wr_data,
               fill_start, fill_value, ram_rdata,
        output disp_rd_valid, disp_rd_data, wr_ready, fill_busy, fill_done,
               wfifo_count, ram_addr, ram_we, ram_wdata
    );
endinterface

// File: rtl/vram_port_arbiter.sv
// Single-port VRAM arbiter: scanout reads win every cycle, posted writes drain through a
// small FIFO in idle cycles, and a flush-then-fill sequencer clears the whole memory.
module vram_port_arbiter #(
    parameter int ADDR_W      = 14,
    parameter int DATA_W      = 16,
    parameter int VRAM_WORDS  = 16384,
    parameter int WFIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    vram_port_arbiter_if.slave bus
);
    localparam int PTR_W = $clog2(WFIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ADDR_W:0]    FILL_LAST = (ADDR_W+1)'(VRAM_WORDS - 1);
    localparam logic [CNT_W-1:0]   FULL_CNT  = CNT_W'(WFIFO_DEPTH);

    typedef enum logic [1:0] {IDLE = 2'd0, FLUSH = 2'd1, FILL = 2'd2} state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_entry_t;

    state_t            state, state_nxt;
    wr_entry_t         fifo_mem [WFIFO_DEPTH];
    wr_entry_t         head;
    logic [PTR_W-1:0]  rd_ptr, wr_ptr;
    logic [CNT_W-1:0]  count;
    logic [ADDR_W:0]   fill_cnt;
    logic [DATA_W-1:0] fill_val;
    logic              rd_vld_q, fill_done_q;
    logic              empty, full, push, pop, fill_wr, fill_last, wr_ready;

    assign empty     = (count == '0);
    assign full      = (count == FULL_CNT);
    assign head      = fifo_mem[rd_ptr];
    assign push      = bus.wr_valid && wr_ready;
    assign pop       = !bus.disp_rd_req && (state != FILL) && !empty;
    assign fill_wr   = !bus.disp_rd_req && (state == FILL);
    assign fill_last = (fill_cnt == FILL_LAST);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // FLUSH only ever pops (ready is low), so it empties once the last entry leaves.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.fill_start) state_nxt = FLUSH;
            FLUSH:   if (empty || (count == CNT_W'(1) && pop)) state_nxt = FILL;
            FILL:    if (fill_wr && fill_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // RAM port mux and handshake outputs
    always_comb begin
        bus.ram_we    = 1'b0;
        bus.ram_addr  = '0;
        bus.ram_wdata = '0;
        if (bus.disp_rd_req) begin
            bus.ram_addr = bus.disp_rd_addr;
        end else if (pop) begin
            bus.ram_we    = 1'b1;
            bus.ram_addr  = head.addr;
            bus.ram_wdata = head.data;
        end else if (state == FILL) begin
            bus.ram_we    = 1'b1;
            bus.ram_addr  = fill_cnt[ADDR_W-1:0];
            bus.ram_wdata = fill_val;
        end
        wr_ready      = (state == IDLE) && !full;
        bus.fill_busy = (state != IDLE);
    end

    assign bus.wr_ready      = wr_ready;
    assign bus.disp_rd_valid = rd_vld_q;
    assign bus.disp_rd_data  = bus.ram_rdata;
    assign bus.fill_done     = fill_done_q;
    assign bus.wfifo_count   = count;

    // Storage needs no reset: pointers and count define what is live.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= '{addr: bus.wr_addr, data: bus.wr_data};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fill_cnt    <= '0;
            fill_val    <= '0;
            fill_done_q <= 1'b0;
            rd_vld_q    <= 1'b0;
        end else begin
            rd_vld_q    <= bus.disp_rd_req;
            fill_done_q <= fill_wr && fill_last;
            if (state == IDLE && bus.fill_start) begin
                fill_cnt <= '0;
                fill_val <= bus.fill_value;
            end else if (fill_wr) begin
                fill_cnt <= fill_cnt + (ADDR_W+1)'(1);
            end
        end
    end
endmodule
